trace_capture_ram: RTL and testbench
====================================

# trace_capture_ram

Circular trace recorder for the detector front end: writes the 12-bit ADC sample stream into an on-chip RAM and, on a trigger, freezes a trace of DEPTH samples that includes PRE pre-trigger samples. It is the write-side counterpart of the existing file-initialised trace ROM. It presents the frozen trace through the same registered address/data read port, so downstream pulse-processing logic can consume either source unchanged.

## Interface
- M, 12, sample word width
- DEPTH, 150, trace length in samples (≤ 1024)
- PRE, 20, pre-trigger samples per trace (1 ≤ PRE < DEPTH)
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-low: reset=0 at a rising edge resets the block
- sample  in  M  ADC sample
- sample_valid  in  1  sample qualifier
- trig  in  1  trigger request; only meaningful with sample_valid=1
- ack  in  1  readout finished, re-arm (one-cycle pulse)
- dir  in  10  logical read index, 0 = oldest pre-trigger sample
- data_out  out  M  registered read data
- armed  out  1  high in ARMED
- ready  out  1  high in DONE (trace frozen)
- lost_trig  out  8  saturating count of triggers rejected in POST/DONE

## Operation
- States: FILL → ARMED → POST → DONE → FILL.
- FILL: every valid sample is written at wr_ptr; wr_ptr increments mod DEPTH; fill_cnt counts to PRE. When the PRE-th sample is written → ARMED. trig is ignored and not counted.
- ARMED: circular writes continue. trig=1 with sample_valid=1 → that sample is written at wr_ptr and becomes logical index PRE. start_ptr ← (wr_ptr − PRE) mod DEPTH, post_cnt ← 1 → POST.
- POST: valid samples are written; post_cnt increments. When the write with post_cnt = DEPTH−PRE completes → DONE. trig is counted in lost_trig.
- DONE: writes are inhibited and memory is frozen. trig is counted in lost_trig. ack=1 → FILL with fill_cnt=0; wr_ptr is kept. ack outside DONE is ignored.
- Read: physical address = (start_ptr + dir) mod DEPTH. Computed without a divider: sum < 2·DEPTH, so subtract DEPTH once if sum ≥ DEPTH.
- data_out = 0 when not in DONE or when dir ≥ DEPTH.
- Reset: state FILL, wr_ptr=0, start_ptr=0, counters 0, data_out=0, armed=0, ready=0, lost_trig=0. RAM contents are not cleared. Reset mid-POST discards the trace.
- sample_valid=0 cycles: no write, no counter advance, in every state.

## Timing
- Write takes effect on the rising edge where sample_valid=1.
- armed rises the cycle after the PRE-th FILL write.
- ready rises the cycle after the final POST write and falls the cycle after ack.
- Read latency: 1 cycle from dir to data_out, as in the trace ROM. A read in the first DONE cycle returns final data.
- armed and ready are never both high.
- lost_trig increments once per cycle with trig=1 and sample_valid=1 in POST/DONE, and holds at 255.

## Structure
- Shared include lago_defs.vh holds:
  - state encoding localparams (ST_FILL, ST_ARMED, ST_POST, ST_DONE)
  - default M, DEPTH and PRE
  - DIR_W=10
- Sub-module trace_dpram: simple dual-port RAM (one write port, one registered read port) of DEPTH×M, inferable as block RAM. The top level holds the FSM, pointers, address wrap and the output gating.

## Test plan
All scenarios use defaults and a ramp stimulus: sample_valid=1 every cycle, sample=n, where n counts valid samples since reset.

1. Basic capture: trig at n=100.
   - ready rises after n=229 is written.
   - dir=0→80, dir=20→100, dir=149→229.
   - dir=150→0.
2. Wrap: trig at n=160 (wr_ptr=10, start_ptr=140).
   - dir=0→140, dir=10→150, dir=149→289.
3. Early trigger: trig at n=5 (FILL).
   - Ignored; lost_trig=0; armed rises after n=19.
   - A later trig at n=30 gives dir=0→10.
4. Lost triggers: 3 trig pulses during POST and 2 during DONE.
   - lost_trig=5; the trace is unchanged.
   - 300 pulses in DONE → lost_trig=255.
5. Gaps and re-arm:
   - sample_valid toggled 1/0 during POST: trace content is identical to scenario 1, and ready is delayed by the gap count.
   - ack in DONE: ready=0 the next cycle, armed returns after 20 more samples.
6. Reset mid-POST: reset=0 for one cycle at n=150.
   - Next cycle: state FILL, data_out=0, ready=0, armed=0, lost_trig=0.

Source files
------------

// File: rtl/trace_capture_ram_pkg.sv
// trace_capture_ram_pkg
//   Shared definitions for the circular trace recorder.
//   - Default sample width, trace length and pre-trigger length.
//   - Width of the logical read index (dir) and of the internal counters.
//   - Capture FSM state type.
package trace_capture_ram_pkg;

    localparam int unsigned M_DEF     = 12;
    localparam int unsigned DEPTH_DEF = 150;
    localparam int unsigned PRE_DEF   = 20;
    localparam int unsigned DIR_W     = 10;

    // One bit wider than dir, so start_ptr + dir (< 2*DEPTH) never overflows.
    localparam int unsigned CNT_W     = DIR_W + 1;

    typedef enum logic [1:0] {
        ST_FILL,
        ST_ARMED,
        ST_POST,
        ST_DONE
    } state_t;

endpackage

// File: rtl/trace_capture_ram_dpram.sv
// trace_dpram
//   Simple dual-port RAM, DEPTH x W, one write port and one registered read
//   port, written so that it maps onto a block RAM.
//   Ports:
//     clk_i    clock
//     we_i     write enable
//     waddr_i  write address
//     wdata_i  write data
//     raddr_i  read address
//     rdata_o  read data, one cycle after raddr_i
module trace_dpram
    import trace_capture_ram_pkg::*;
#(
    parameter int unsigned W     = M_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned AW    = 8
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/trace_capture_ram.sv
// trace_capture_ram
//   Circular trace recorder. Writes the ADC sample stream into a RAM and, on a
//   trigger, freezes a trace of DEPTH samples of which PRE precede the trigger.
//   The frozen trace is read through a registered address/data port.
//   Ports:
//     clk           clock, rising edge
//     reset         synchronous, active-low
//     sample        ADC sample
//     sample_valid  sample qualifier
//     trig          trigger request (meaningful with sample_valid=1)
//     ack           readout finished, re-arm (only honoured when ready)
//     dir           logical read index, 0 = oldest pre-trigger sample
//     data_out      read data, 1 cycle after dir; 0 unless frozen and dir < DEPTH
//     armed         waiting for a trigger
//     ready         trace frozen
//     lost_trig     saturating count of triggers rejected while capturing/frozen
module trace_capture_ram
    import trace_capture_ram_pkg::*;
#(
    parameter int unsigned M     = M_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned PRE   = PRE_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [M-1:0]     sample,
    input  logic             sample_valid,
    input  logic             trig,
    input  logic             ack,
    input  logic [DIR_W-1:0] dir,
    output logic [M-1:0]     data_out,
    output logic             armed,
    output logic             ready,
    output logic [7:0]       lost_trig
);

    localparam int unsigned      PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] PRE_C    = CNT_W'(PRE);
    localparam logic [CNT_W-1:0] POST_LEN = CNT_W'(DEPTH - PRE);

    state_t           state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] start_ptr_q, start_ptr_d;
    logic [CNT_W-1:0] fill_cnt_q, fill_cnt_d;
    logic [CNT_W-1:0] post_cnt_q, post_cnt_d;
    logic [7:0]       lost_q, lost_d;
    logic             rd_ok_q, rd_ok_d;

    logic             we;
    logic [PTR_W-1:0] wr_ptr_inc;
    logic [CNT_W-1:0] wr_ext;
    logic [CNT_W-1:0] start_calc;
    logic [CNT_W-1:0] fill_nxt;
    logic [CNT_W-1:0] post_nxt;

    logic [CNT_W-1:0] dir_ext;
    logic [CNT_W-1:0] rd_sum;
    logic             dir_in_range;
    logic [PTR_W-1:0] rd_addr;
    logic [M-1:0]     ram_rdata;

    // Capture FSM, pointers and counters.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        start_ptr_d = start_ptr_q;
        fill_cnt_d  = fill_cnt_q;
        post_cnt_d  = post_cnt_q;
        lost_d      = lost_q;
        we          = 1'b0;

        wr_ptr_inc  = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
        fill_nxt    = fill_cnt_q + CNT_W'(1);
        post_nxt    = post_cnt_q + CNT_W'(1);

        // (wr_ptr - PRE) mod DEPTH without a divider: wr_ptr < DEPTH, PRE < DEPTH.
        wr_ext      = CNT_W'(wr_ptr_q);
        start_calc  = (wr_ext >= PRE_C) ? (wr_ext - PRE_C) : (wr_ext + DEPTH_C - PRE_C);

        if (sample_valid) begin
            if (state_q != ST_DONE) begin
                we       = 1'b1;
                wr_ptr_d = wr_ptr_inc;
            end

            if (trig && (state_q == ST_POST || state_q == ST_DONE) && lost_q != 8'hFF) begin
                lost_d = lost_q + 8'd1;
            end

            case (state_q)
                ST_FILL: begin
                    fill_cnt_d = fill_nxt;
                    if (fill_nxt == PRE_C) begin
                        state_d = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (trig) begin
                        // The trigger sample itself is the first post-trigger write.
                        start_ptr_d = PTR_W'(start_calc);
                        post_cnt_d  = CNT_W'(1);
                        state_d     = (POST_LEN == CNT_W'(1)) ? ST_DONE : ST_POST;
                    end
                end
                ST_POST: begin
                    post_cnt_d = post_nxt;
                    if (post_nxt == POST_LEN) begin
                        state_d = ST_DONE;
                    end
                end
                default: ;
            endcase
        end

        if (state_q == ST_DONE && ack) begin
            state_d    = ST_FILL;
            fill_cnt_d = '0;
        end
    end

    // Read address: start_ptr + dir < 2*DEPTH whenever dir is in range, so a
    // single conditional subtract wraps it.
    always_comb begin
        dir_ext      = CNT_W'(dir);
        rd_sum       = CNT_W'(start_ptr_q) + dir_ext;
        dir_in_range = (dir_ext < DEPTH_C);
        rd_addr      = '0;
        if (dir_in_range) begin
            rd_addr = (rd_sum >= DEPTH_C) ? PTR_W'(rd_sum - DEPTH_C) : PTR_W'(rd_sum);
        end
        rd_ok_d = (state_q == ST_DONE) && dir_in_range;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_FILL;
            wr_ptr_q    <= '0;
            start_ptr_q <= '0;
            fill_cnt_q  <= '0;
            post_cnt_q  <= '0;
            lost_q      <= '0;
            rd_ok_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            start_ptr_q <= start_ptr_d;
            fill_cnt_q  <= fill_cnt_d;
            post_cnt_q  <= post_cnt_d;
            lost_q      <= lost_d;
            rd_ok_q     <= rd_ok_d;
        end
    end

    trace_dpram #(
        .W     (M),
        .DEPTH (DEPTH),
        .AW    (PTR_W)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (we),
        .waddr_i (wr_ptr_q),
        .wdata_i (sample),
        .raddr_i (rd_addr),
        .rdata_o (ram_rdata)
    );

    // RAM output register is not reset; the qualifier registered alongside it
    // forces zero after reset, outside DONE and for out-of-range indices.
    assign data_out  = rd_ok_q ? ram_rdata : '0;
    assign armed     = (state_q == ST_ARMED);
    assign ready     = (state_q == ST_DONE);
    assign lost_trig = lost_q;

endmodule

// File: tb/tb_trace_capture_ram.sv
module tb_trace_capture_ram;
    import trace_capture_ram_pkg::*;

    localparam int M     = 12;
    localparam int DEPTH = 150;
    localparam int PRE   = 20;

    logic             clk = 1'b0;
    logic             reset;
    logic [M-1:0]     sample;
    logic             sample_valid;
    logic             trig;
    logic             ack;
    logic [DIR_W-1:0] dir;
    logic [M-1:0]     data_out;
    logic             armed;
    logic             ready;
    logic [7:0]       lost_trig;

    always #5 clk = ~clk;

    trace_capture_ram #(
        .M     (M),
        .DEPTH (DEPTH),
        .PRE   (PRE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sample       (sample),
        .sample_valid (sample_valid),
        .trig         (trig),
        .ack          (ack),
        .dir          (dir),
        .data_out     (data_out),
        .armed        (armed),
        .ready        (ready),
        .lost_trig    (lost_trig)
    );

    typedef struct {
        int unsigned  cyc;
        logic [M-1:0] data;
        logic         armed;
        logic         ready;
        logic [7:0]   lost;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int unsigned cyc = 0;

    // Reference model: phase 0 collecting pre-trigger samples, 1 waiting for
    // a trigger, 2 collecting post-trigger samples, 3 frozen. The frozen trace
    // is simply the last DEPTH samples written when capture completes.
    int m_phase = 0;
    int m_fill  = 0;
    int m_post  = 0;
    int m_lost  = 0;
    int hist[$];
    int trace[DEPTH];

    task automatic chk(input string name, input int unsigned c,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, c, act, exp);
        end
    endtask

    task automatic freeze();
        for (int i = 0; i < DEPTH; i++) trace[i] = hist[i];
        m_phase = 3;
    endtask

    // Drive one cycle of inputs, advance the model, queue the expected outputs
    // seen after the clock edge. want >= 0 overrides the expected data_out.
    task automatic step(input logic rst_n, input logic v, input int s,
                        input logic t, input logic a, input int d, input int want);
        exp_t e;
        reset        = rst_n;
        sample_valid = v;
        sample       = M'(s);
        trig         = t;
        ack          = a;
        dir          = DIR_W'(d);
        if (!rst_n) begin
            m_phase = 0; m_fill = 0; m_post = 0; m_lost = 0;
            hist.delete();
            e.data = '0;
        end else begin
            e.data = (m_phase == 3 && d < DEPTH) ? M'(trace[d]) : '0;
            if (v && m_phase != 3) begin
                hist.push_back(s % 4096);
                if (hist.size() > DEPTH) void'(hist.pop_front());
            end
            if (v && t && m_phase >= 2 && m_lost < 255) m_lost++;
            case (m_phase)
                0: if (v) begin
                       m_fill++;
                       if (m_fill == PRE) m_phase = 1;
                   end
                1: if (v && t) begin
                       m_post = 1;
                       if (m_post == DEPTH - PRE) freeze(); else m_phase = 2;
                   end
                2: if (v) begin
                       m_post++;
                       if (m_post == DEPTH - PRE) freeze();
                   end
                default: if (a) begin
                       m_phase = 0;
                       m_fill  = 0;
                   end
            endcase
        end
        if (want >= 0) e.data = M'(want);
        e.armed = (m_phase == 1);
        e.ready = (m_phase == 3);
        e.lost  = 8'(m_lost);
        e.cyc   = cyc;
        @(posedge clk);
        sb.push_back(e);
        cyc++;
        #1;
    endtask

    // Monitor: outputs are presented every cycle; compare after each edge.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("data_out",  e.cyc, 32'(data_out),  32'(e.data));
            chk("armed",     e.cyc, 32'(armed),     32'(e.armed));
            chk("ready",     e.cyc, 32'(ready),     32'(e.ready));
            chk("lost_trig", e.cyc, 32'(lost_trig), 32'(e.lost));
        end
    end

    initial begin
        int n;
        int guard;
        logic r, v, t, a;
        int d;

        step(1'b0, 1'b0, 0, 1'b0, 1'b0, 0, -1);
        step(1'b0, 1'b0, 0, 1'b0, 1'b0, 0, -1);

        // Ramp: early trigger in FILL (ignored), real trigger at n=100,
        // three rejected triggers during POST.
        n = 0;
        guard = 0;
        while (!ready && guard < 400) begin
            t = (n == 5 || n == 100 || n == 110 || n == 120 || n == 130);
            step(1'b1, 1'b1, n, t, 1'b0, 0, -1);
            n++;
            guard++;
        end
        if (!ready) begin
            errors++;
            $display("FAIL ready_timeout cycle=%0d got=0 expected=1", cyc);
        end
        chk("samples_before_ready", cyc, 32'(n), 32'd230);

        // Frozen trace reads plus two rejected triggers in DONE.
        step(1'b1, 1'b1, n, 1'b1, 1'b0, 0,   80);  n++;
        step(1'b1, 1'b1, n, 1'b1, 1'b0, 20,  100); n++;
        step(1'b1, 1'b1, n, 1'b0, 1'b0, 149, 229); n++;
        step(1'b1, 1'b1, n, 1'b0, 1'b0, 150, 0);   n++;
        chk("lost_after_5", cyc, 32'(lost_trig), 32'd5);

        for (int i = 0; i < 300; i++) begin
            step(1'b1, 1'b1, n, 1'b1, 1'b0, $urandom_range(0, 149), -1);
            n++;
        end
        chk("lost_saturated", cyc, 32'(lost_trig), 32'd255);

        step(1'b1, 1'b1, n, 1'b0, 1'b1, 0, -1); n++;
        chk("ready_after_ack", cyc, 32'(ready), 32'd0);

        // Randomized traffic: gaps, triggers anywhere, acks, occasional reset.
        for (int i = 0; i < 20000; i++) begin
            r = ($urandom % 2000) != 0;
            v = ($urandom % 4) != 0;
            t = ($urandom % 60) == 0;
            a = (m_phase == 3) && (($urandom % 6) == 0);
            d = (($urandom % 10) == 0) ? int'($urandom_range(150, 1023))
                                       : int'($urandom_range(0, 149));
            step(r, v, int'($urandom_range(0, 4095)), t, a, d, -1);
        end

        // Reset in the middle of POST discards the trace.
        step(1'b0, 1'b0, 0, 1'b0, 1'b0, 0, -1);
        for (int k = 0; k < 150; k++) begin
            step(1'b1, 1'b1, k, (k == 100), 1'b0, 0, -1);
        end
        step(1'b0, 1'b1, 150, 1'b0, 1'b0, 0, -1);
        chk("rst_ready",  cyc, 32'(ready),     32'd0);
        chk("rst_armed",  cyc, 32'(armed),     32'd0);
        chk("rst_lost",   cyc, 32'(lost_trig), 32'd0);
        chk("rst_data",   cyc, 32'(data_out),  32'd0);
        step(1'b1, 1'b1, 151, 1'b0, 1'b0, 0, -1);

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain cycle=%0d got=%0d expected=0", cyc, sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
